median_line_window: RTL and testbench

//   Upstream stage of median_filter. Turns one raster pixel stream into vertical 3-tap windows.

---
 rtl/median_line_window_if.sv | 34 +++
 rtl/median_line_window.sv | 156 +++++++++++++++
 tb/tb_median_line_window.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/median_line_window_if.sv
`default_nettype none
// ============================================================================
// median_line_window_if
//   Pixel-in / window-out handshake bundle for median_line_window.
//   Rev 1.0 - initial release
// ============================================================================
interface median_line_window_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 6
);
   logic              in_valid;
   logic              in_ready;
   logic              in_sof;
   logic [WIDTH-1:0]  in_data;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_word0;
   logic [WIDTH-1:0]  out_word1;
   logic [WIDTH-1:0]  out_word2;
   logic [ADDR_W-1:0] out_col;
   logic              primed;

   // master drives pixels and consumes windows; slave is the window builder
   modport master (
      output in_valid, in_sof, in_data, out_ready,
      input  in_ready, out_valid, out_word0, out_word1, out_word2, out_col, primed
   );

   modport slave (
      input  in_valid, in_sof, in_data, out_ready,
      output in_ready, out_valid, out_word0, out_word1, out_word2, out_col, primed
   );
endinterface
`default_nettype wire

// File: rtl/median_line_window.sv
`default_nettype none
// ============================================================================
// median_line_window
//   Builds vertical 3-tap windows (rows r-2, r-1, r) from a raster pixel
//   stream using two line buffers. Optional macro MEDIAN_WIN_BORDER_EN emits
//   top-border windows with edge replication.
//   Rev 1.0 - initial release
// ============================================================================
module median_line_window #(
   parameter int WIDTH  = 32,
   parameter int LINE_W = 64,
   parameter int ADDR_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   median_line_window_if.slave bus
);

   localparam logic [ADDR_W-1:0] C_LAST_COL = ADDR_W'(LINE_W - 1);

   typedef enum logic [1:0] {
      ROW_0      = 2'd0,
      ROW_1      = 2'd1,
      ROW_PRIMED = 2'd2
   } row_state_t;

   row_state_t        r_state;
   row_state_t        w_state_nxt;
   row_state_t        w_eff_row;

   logic [WIDTH-1:0]  r_line_a [LINE_W];
   logic [WIDTH-1:0]  r_line_b [LINE_W];

   logic [ADDR_W-1:0] r_col;
   logic [ADDR_W-1:0] w_col;
   logic [ADDR_W-1:0] w_col_nxt;
   logic              w_wrap;

   logic              r_out_valid;
   logic              w_out_valid_nxt;
   logic [WIDTH-1:0]  r_word0;
   logic [WIDTH-1:0]  r_word1;
   logic [WIDTH-1:0]  r_word2;
   logic [ADDR_W-1:0] r_out_col;

   logic              w_in_ready;
   logic              w_accept;
   logic              w_produce;
   logic [WIDTH-1:0]  w_rd_a;
   logic [WIDTH-1:0]  w_rd_b;
   logic [WIDTH-1:0]  w_word0;
   logic [WIDTH-1:0]  w_word1;

   assign w_in_ready = !r_out_valid || bus.out_ready;
   assign w_accept   = bus.in_valid && w_in_ready;

   // A start-of-frame beat is always column 0 of row 0, whatever was in flight.
   assign w_col     = bus.in_sof ? '0 : r_col;
   assign w_eff_row = bus.in_sof ? ROW_0 : r_state;
   assign w_wrap    = (w_col == C_LAST_COL);

   assign w_rd_a = r_line_a[w_col];
   assign w_rd_b = r_line_b[w_col];

   always_comb begin
      w_state_nxt = r_state;
      w_col_nxt   = r_col;
      if (w_accept) begin
         w_col_nxt   = w_wrap ? '0 : w_col + 1'b1;
         w_state_nxt = w_eff_row;
         if (w_wrap) begin
            case (w_eff_row)
               ROW_0:   w_state_nxt = ROW_1;
               ROW_1:   w_state_nxt = ROW_PRIMED;
               default: w_state_nxt = ROW_PRIMED;
            endcase
         end
      end
   end

   always_comb begin
      w_word0   = w_rd_a;
      w_word1   = w_rd_b;
      w_produce = w_accept && (w_eff_row == ROW_PRIMED);
`ifdef MEDIAN_WIN_BORDER_EN
      w_produce = w_accept;
      case (w_eff_row)
         ROW_0: begin
            w_word0 = bus.in_data;
            w_word1 = bus.in_data;
         end
         ROW_1: begin
            w_word0 = w_rd_b;
            w_word1 = w_rd_b;
         end
         default: begin
            w_word0 = w_rd_a;
            w_word1 = w_rd_b;
         end
      endcase
`else
      w_word0   = w_rd_a;
      w_word1   = w_rd_b;
`endif
   end

   // A new window wins over retirement when both happen in one cycle.
   always_comb begin
      w_out_valid_nxt = r_out_valid;
      if (w_produce) begin
         w_out_valid_nxt = 1'b1;
      end else if (bus.out_ready) begin
         w_out_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ROW_0;
         r_col       <= '0;
         r_out_valid <= 1'b0;
         r_word0     <= '0;
         r_word1     <= '0;
         r_word2     <= '0;
         r_out_col   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_col       <= w_col_nxt;
         r_out_valid <= w_out_valid_nxt;
         if (w_accept) begin
            r_word0   <= w_word0;
            r_word1   <= w_word1;
            r_word2   <= bus.in_data;
            r_out_col <= w_col;
         end
      end
   end

   // Line buffers carry no reset; stale contents are masked until primed.
   always_ff @(posedge clk) begin
      if (rst_n && w_accept) begin
         r_line_a[w_col] <= w_rd_b;
         r_line_b[w_col] <= bus.in_data;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_word0 = r_word0;
   assign bus.out_word1 = r_word1;
   assign bus.out_word2 = r_word2;
   assign bus.out_col   = r_out_col;
   assign bus.primed    = (r_state == ROW_PRIMED);

endmodule
`default_nettype wire

// File: tb/tb_median_line_window.sv
`default_nettype none
// ============================================================================
// tb_median_line_window
//   Directed and randomized bench with a frame-history reference model.
//   Rev 1.0 - initial release
// ============================================================================
module tb_median_line_window;

   localparam int WIDTH  = 32;
   localparam int LINE_W = 4;
   localparam int ADDR_W = 2;

   typedef struct packed {
      logic [WIDTH-1:0]  w0;
      logic [WIDTH-1:0]  w1;
      logic [WIDTH-1:0]  w2;
      logic [ADDR_W-1:0] col;
   } win_t;

   logic clk = 1'b0;
   logic rst_n;

   median_line_window_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   median_line_window #(.WIDTH(WIDTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference: every pixel of the current frame, in raster order.
   logic [WIDTH-1:0] hist [$];
   win_t             exp_q [$];

   logic              s_valid, s_ready, s_primed, s_ordy, e_primed;
   logic [WIDTH-1:0]  s_w0, s_w1, s_w2;
   logic [ADDR_W-1:0] s_col;
   int                s_qn;

   task automatic model_reset();
      hist.delete();
      exp_q.delete();
   endtask

   task automatic model_beat(input logic sof, input logic [WIDTH-1:0] d);
      int   n, row, col;
      win_t w;
      if (sof) hist.delete();
      hist.push_back(d);
      n   = hist.size() - 1;
      row = n / LINE_W;
      col = n % LINE_W;
      w.w2  = d;
      w.col = ADDR_W'(col);
      if (row >= 2) begin
         w.w0 = hist[n - 2*LINE_W];
         w.w1 = hist[n - LINE_W];
         exp_q.push_back(w);
      end
`ifdef MEDIAN_WIN_BORDER_EN
      else if (row == 1) begin
         w.w0 = hist[n - LINE_W];
         w.w1 = hist[n - LINE_W];
         exp_q.push_back(w);
      end else begin
         w.w0 = d;
         w.w1 = d;
         exp_q.push_back(w);
      end
`endif
   endtask

   // One clock: drive, sample at negedge, advance the model on acceptance.
   task automatic cycle(input logic v, input logic sof, input logic [WIDTH-1:0] d,
                        input logic ordy);
      bus.in_valid  = v;
      bus.in_sof    = sof;
      bus.in_data   = d;
      bus.out_ready = ordy;
      @(negedge clk);
      s_valid  = bus.out_valid;
      s_ready  = bus.in_ready;
      s_w0     = bus.out_word0;
      s_w1     = bus.out_word1;
      s_w2     = bus.out_word2;
      s_col    = bus.out_col;
      s_primed = bus.primed;
      s_ordy   = ordy;
      s_qn     = exp_q.size();
      e_primed = (hist.size() >= 2*LINE_W);
      if (v && s_ready) model_beat(sof, d);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b1;
      bus.in_sof    = 1'b0;
      bus.in_data   = 32'hDEAD_BEEF;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      model_reset();
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
      end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
      end
      n_checks++;
      if ({bus.out_word0, bus.out_word1, bus.out_word2} !== '0) begin
         n_fails++;
         $display("FAIL reset_words: got %h %h %h, required 0", bus.out_word0, bus.out_word1, bus.out_word2);
      end
      n_checks++;
      if (bus.out_col !== '0) begin
         n_fails++;
         $display("FAIL reset_col: got %0d, required 0", bus.out_col);
      end
      n_checks++;
      if (bus.primed !== 1'b0) begin
         n_fails++;
         $display("FAIL reset_primed: got %b, required 0", bus.primed);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_stream();
      win_t e;
      int   k = 0;
      for (int i = 1; i <= 12; i++) begin
         cycle(1'b1, (i == 1), WIDTH'(i), 1'b1);
         if (s_valid) begin
            n_checks++;
            if (s_qn == 0) begin
               n_fails++;
               $display("FAIL stream_extra: window %0d %0d %0d seen, required none", s_w0, s_w1, s_w2);
            end else begin
               e = exp_q[0];
               if ({s_w0, s_w1, s_w2, s_col} !== e) begin
                  n_fails++;
                  $display("FAIL stream_window: got %0d %0d %0d col %0d, required %0d %0d %0d col %0d",
                           s_w0, s_w1, s_w2, s_col, e.w0, e.w1, e.w2, e.col);
               end
               void'(exp_q.pop_front());
            end
`ifndef MEDIAN_WIN_BORDER_EN
            n_checks++;
            if ({s_w0, s_w1, s_w2, s_col} !== {WIDTH'(k+1), WIDTH'(k+5), WIDTH'(k+9), ADDR_W'(k)}) begin
               n_fails++;
               $display("FAIL stream_literal: got %0d %0d %0d col %0d, required %0d %0d %0d col %0d",
                        s_w0, s_w1, s_w2, s_col, k+1, k+5, k+9, k);
            end
            k++;
`endif
         end else begin
            n_checks++;
            if (s_qn != 0) begin
               n_fails++;
               $display("FAIL stream_missing: out_valid 0, required 1");
            end
         end
         n_checks++;
         if (s_primed !== e_primed) begin
            n_fails++;
            $display("FAIL stream_primed: got %b, required %b", s_primed, e_primed);
         end
      end
   endtask

   task automatic test_backpressure();
      win_t e;
      cycle(1'b1, 1'b0, WIDTH'(13), 1'b1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, WIDTH'(14), 1'b0);
         n_checks++;
         if (s_valid !== 1'b1 || s_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL stall_handshake: out_valid %b in_ready %b, required 1 0", s_valid, s_ready);
         end
         n_checks++;
`ifndef MEDIAN_WIN_BORDER_EN
         if ({s_w0, s_w1, s_w2, s_col} !== {WIDTH'(5), WIDTH'(9), WIDTH'(13), ADDR_W'(0)}) begin
            n_fails++;
            $display("FAIL stall_hold: got %0d %0d %0d col %0d, required 5 9 13 col 0", s_w0, s_w1, s_w2, s_col);
         end
`else
         e = exp_q[0];
         if ({s_w0, s_w1, s_w2, s_col} !== e) begin
            n_fails++;
            $display("FAIL stall_hold: got %0d %0d %0d, required %0d %0d %0d", s_w0, s_w1, s_w2, e.w0, e.w1, e.w2);
         end
`endif
      end
      for (int i = 14; i <= 16; i++) begin
         cycle(1'b1, 1'b0, WIDTH'(i), 1'b1);
         n_checks++;
         if (!s_valid || s_qn == 0) begin
            n_fails++;
            $display("FAIL release_valid: out_valid %b pending %0d, required 1 and >0", s_valid, s_qn);
         end else begin
            e = exp_q[0];
            if ({s_w0, s_w1, s_w2, s_col} !== e) begin
               n_fails++;
               $display("FAIL release_window: got %0d %0d %0d col %0d, required %0d %0d %0d col %0d",
                        s_w0, s_w1, s_w2, s_col, e.w0, e.w1, e.w2, e.col);
            end
            void'(exp_q.pop_front());
         end
      end
   endtask

   task automatic test_restart();
      win_t e;
      logic seen_108 = 1'b0;
      logic [WIDTH-1:0] seq [14];
      seq[0] = 17;
      seq[1] = 18;
      for (int i = 0; i < 12; i++) seq[i+2] = WIDTH'(100 + i);
      for (int i = 0; i < 14 + 4; i++) begin
         if (i < 14) cycle(1'b1, (i == 2), seq[i], 1'b1);
         else        cycle(1'b0, 1'b0, '0, 1'b1);
         if (s_valid) begin
            n_checks++;
            if (s_qn == 0) begin
               n_fails++;
               $display("FAIL restart_extra: window %0d %0d %0d seen, required none", s_w0, s_w1, s_w2);
            end else begin
               e = exp_q[0];
               if ({s_w0, s_w1, s_w2, s_col} !== e) begin
                  n_fails++;
                  $display("FAIL restart_window: got %0d %0d %0d col %0d, required %0d %0d %0d col %0d",
                           s_w0, s_w1, s_w2, s_col, e.w0, e.w1, e.w2, e.col);
               end
               void'(exp_q.pop_front());
            end
            if (s_w2 == 108) begin
               seen_108 = 1'b1;
`ifndef MEDIAN_WIN_BORDER_EN
               n_checks++;
               if ({s_w0, s_w1, s_col} !== {WIDTH'(100), WIDTH'(104), ADDR_W'(0)}) begin
                  n_fails++;
                  $display("FAIL restart_first: got %0d %0d 108 col %0d, required 100 104 108 col 0", s_w0, s_w1, s_col);
               end
`endif
            end
         end else begin
            n_checks++;
            if (s_qn != 0) begin
               n_fails++;
               $display("FAIL restart_missing: out_valid 0, required 1");
            end
         end
         n_checks++;
         if (s_primed !== e_primed) begin
            n_fails++;
            $display("FAIL restart_primed: got %b, required %b", s_primed, e_primed);
         end
      end
      n_checks++;
      if (!seen_108 || exp_q.size() != 0) begin
         n_fails++;
         $display("FAIL restart_drain: saw_108 %b pending %0d, required 1 0", seen_108, exp_q.size());
      end
   endtask

`ifdef MEDIAN_WIN_BORDER_EN
   task automatic test_border();
      win_t e;
      int   k = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 1; i <= 9; i++) begin
         if (i <= 8) cycle(1'b1, (i == 1), WIDTH'(i), 1'b1);
         else        cycle(1'b0, 1'b0, '0, 1'b1);
         if (s_valid) begin
            n_checks++;
            e = (k < 4) ? {WIDTH'(k+1), WIDTH'(k+1), WIDTH'(k+1), ADDR_W'(k)}
                        : {WIDTH'(k-3), WIDTH'(k-3), WIDTH'(k+1), ADDR_W'(k-4)};
            if ({s_w0, s_w1, s_w2, s_col} !== e) begin
               n_fails++;
               $display("FAIL border_window: got %0d %0d %0d col %0d, required %0d %0d %0d col %0d",
                        s_w0, s_w1, s_w2, s_col, e.w0, e.w1, e.w2, e.col);
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            k++;
         end
      end
      n_checks++;
      if (k != 8) begin
         n_fails++;
         $display("FAIL border_count: got %0d windows, required 8", k);
      end
   endtask
`endif

   task automatic test_random();
      win_t e;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(99) == 0) begin
            rst_n        = 1'b0;
            bus.in_valid = 1'($urandom);
            @(posedge clk);
            #1;
            rst_n        = 1'b1;
            bus.in_valid = 1'b0;
            model_reset();
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.primed !== 1'b0) begin
               n_fails++;
               $display("FAIL rand_reset: out_valid %b primed %b, required 0 0", bus.out_valid, bus.primed);
            end
            @(posedge clk);
            #1;
         end else begin
            cycle(($urandom_range(99) < 75), ($urandom_range(99) < 3), $urandom,
                  ($urandom_range(99) < 65));
            n_checks++;
            if (s_ready !== (!s_valid || s_ordy)) begin
               n_fails++;
               $display("FAIL rand_in_ready: got %b, required %b", s_ready, (!s_valid || s_ordy));
            end
            if (s_valid) begin
               n_checks++;
               if (s_qn == 0) begin
                  n_fails++;
                  $display("FAIL rand_extra: window %h %h %h seen, required none", s_w0, s_w1, s_w2);
               end else begin
                  e = exp_q[0];
                  if ({s_w0, s_w1, s_w2, s_col} !== e) begin
                     n_fails++;
                     $display("FAIL rand_window: got %h %h %h col %0d, required %h %h %h col %0d",
                              s_w0, s_w1, s_w2, s_col, e.w0, e.w1, e.w2, e.col);
                  end
                  if (s_ordy) void'(exp_q.pop_front());
               end
            end else begin
               n_checks++;
               if (s_qn != 0) begin
                  n_fails++;
                  $display("FAIL rand_missing: out_valid 0, required 1");
               end
            end
            n_checks++;
            if (s_primed !== e_primed) begin
               n_fails++;
               $display("FAIL rand_primed: got %b, required %b", s_primed, e_primed);
            end
         end
      end
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
         cycle(1'b0, 1'b0, '0, 1'b1);
         if (s_valid && s_qn > 0) void'(exp_q.pop_front());
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fails++;
         $display("FAIL rand_drain: pending %0d, required 0", exp_q.size());
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sof    = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_restart();
`ifdef MEDIAN_WIN_BORDER_EN
      test_border();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
